// File: rtl/mem_access.sv
// -----------------------------------------------------------------------------
// mem_access - memory-stage access unit of the 5-level MIPS pipeline.
//
// Takes the load/store fields from the EX/MEM register and runs byte, halfword
// and word accesses on a req/ack data bus. The pipeline is held (stall_req)
// until the bus acknowledges, then the writeback triple goes on to MEM/WB.
// Lanes are big-endian: byte offset 0 is bits [31:24].
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   op_i                  op from EX/MEM (E0..EB are loads/stores)
//   num2_i                store data (rt)
//   ram_addr_i            effective byte address
//   en_wd_i               register write enable from EX/MEM
//   desReg_addr_i         destination register
//   result_i              ALU result from EX/MEM
//   mem_hold              controller stall of this stage
//   en_wd_o               write enable to MEM/WB and forwarding
//   desReg_addr_o         destination register, pass-through
//   result_o              writeback data
//   stall_req             stall request to controller
//   bus_req/we/addr/sel/wdata   registered bus request outputs
//   bus_rdata, bus_ack    read data and one-cycle completion pulse
//   excp_adel, excp_ades  misaligned load / store (combinational)
// -----------------------------------------------------------------------------
module mem_access (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  op_i,
    input  logic [31:0] num2_i,
    input  logic [31:0] ram_addr_i,
    input  logic        en_wd_i,
    input  logic [4:0]  desReg_addr_i,
    input  logic [31:0] result_i,
    input  logic        mem_hold,
    output logic        en_wd_o,
    output logic [4:0]  desReg_addr_o,
    output logic [31:0] result_o,
    output logic        stall_req,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_sel,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic        excp_adel,
    output logic        excp_ades
);

    localparam logic [7:0] OP_LB  = 8'hE0;
    localparam logic [7:0] OP_LH  = 8'hE1;
    localparam logic [7:0] OP_LW  = 8'hE3;
    localparam logic [7:0] OP_LBU = 8'hE4;
    localparam logic [7:0] OP_LHU = 8'hE5;
    localparam logic [7:0] OP_SB  = 8'hE8;
    localparam logic [7:0] OP_SH  = 8'hE9;
    localparam logic [7:0] OP_SW  = 8'hEB;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Byte-lane enables for an access of the given size at offset a.
    function automatic logic [3:0] lane_sel(input logic [1:0] size, input logic [1:0] a);
        logic [3:0] sel;
        sel = 4'b1111;
        case (size)
            SZ_BYTE: sel = 4'b1000 >> a;
            SZ_HALF: sel = a[1] ? 4'b0011 : 4'b1100;
            default: sel = 4'b1111;
        endcase
        return sel;
    endfunction

    // Replicate store data across every lane so the slave just honours sel.
    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] d);
        logic [31:0] w;
        w = d;
        case (size)
            SZ_BYTE: w = {4{d[7:0]}};
            SZ_HALF: w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

    // Pull the addressed byte/half out of a read word and extend it.
    function automatic logic [31:0] load_extract(input logic [1:0] size, input logic sext,
                                                 input logic [1:0] a, input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = 8'h00;
        case (a)
            2'd0:    b = d[31:24];
            2'd1:    b = d[23:16];
            2'd2:    b = d[15:8];
            2'd3:    b = d[7:0];
            default: b = 8'h00;
        endcase
        h = a[1] ? d[15:0] : d[31:16];
        case (size)
            SZ_BYTE: r = {{24{sext & b[7]}}, b};
            SZ_HALF: r = {{16{sext & h[15]}}, h};
            default: r = d;
        endcase
        return r;
    endfunction

    state_t      state_r, state_s;
    logic        bus_req_r, bus_req_s;
    logic        bus_we_r, bus_we_s;
    logic [31:0] bus_addr_r, bus_addr_s;
    logic [3:0]  bus_sel_r, bus_sel_s;
    logic [31:0] bus_wdata_r, bus_wdata_s;
    logic [31:0] rdata_r, rdata_s;

    logic        is_load_s;
    logic        is_store_s;
    logic        sext_s;
    logic [1:0]  size_s;
    logic        misalign_s;
    logic        mem_op_s;

    // Opcode decode: load/store class, access size and sign extension.
    always_comb begin
        is_load_s  = 1'b0;
        is_store_s = 1'b0;
        sext_s     = 1'b0;
        size_s     = SZ_WORD;
        case (op_i)
            OP_LB:   begin is_load_s  = 1'b1; sext_s = 1'b1; size_s = SZ_BYTE; end
            OP_LH:   begin is_load_s  = 1'b1; sext_s = 1'b1; size_s = SZ_HALF; end
            OP_LW:   begin is_load_s  = 1'b1; size_s = SZ_WORD; end
            OP_LBU:  begin is_load_s  = 1'b1; size_s = SZ_BYTE; end
            OP_LHU:  begin is_load_s  = 1'b1; size_s = SZ_HALF; end
            OP_SB:   begin is_store_s = 1'b1; size_s = SZ_BYTE; end
            OP_SH:   begin is_store_s = 1'b1; size_s = SZ_HALF; end
            OP_SW:   begin is_store_s = 1'b1; size_s = SZ_WORD; end
            default: begin is_load_s  = 1'b0; is_store_s = 1'b0; end
        endcase
    end

    // Alignment check; a misaligned op never reaches the bus.
    always_comb begin
        if (size_s == SZ_HALF) begin
            misalign_s = ram_addr_i[0];
        end else if (size_s == SZ_WORD) begin
            misalign_s = (ram_addr_i[1:0] != 2'b00);
        end else begin
            misalign_s = 1'b0;
        end
    end

    assign mem_op_s  = (is_load_s | is_store_s) & ~misalign_s;
    assign excp_adel = is_load_s & misalign_s;
    assign excp_ades = is_store_s & misalign_s;

    // Next-state and next bus-register values.
    always_comb begin
        state_s     = state_r;
        bus_req_s   = bus_req_r;
        bus_we_s    = bus_we_r;
        bus_addr_s  = bus_addr_r;
        bus_sel_s   = bus_sel_r;
        bus_wdata_s = bus_wdata_r;
        rdata_s     = rdata_r;
        case (state_r)
            IDLE: begin
                if (mem_op_s) begin
                    state_s     = BUSY;
                    bus_req_s   = 1'b1;
                    bus_we_s    = is_store_s;
                    bus_addr_s  = {ram_addr_i[31:2], 2'b00};
                    bus_sel_s   = lane_sel(size_s, ram_addr_i[1:0]);
                    bus_wdata_s = lane_wdata(size_s, num2_i);
                end else begin
                    state_s = IDLE;
                end
            end
            BUSY: begin
                if (bus_ack) begin
                    state_s   = DONE;
                    bus_req_s = 1'b0;
                    rdata_s   = bus_rdata;
                end else begin
                    state_s = BUSY;
                end
            end
            DONE: begin
                // The op still on the inputs is the finished instruction;
                // it is never reissued, only released when the stage moves.
                if (mem_hold) begin
                    state_s = DONE;
                end else begin
                    state_s = IDLE;
                end
            end
            default: begin
                state_s   = IDLE;
                bus_req_s = 1'b0;
            end
        endcase
    end

    // State and bus registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            bus_req_r   <= 1'b0;
            bus_we_r    <= 1'b0;
            bus_addr_r  <= 32'h0000_0000;
            bus_sel_r   <= 4'b0000;
            bus_wdata_r <= 32'h0000_0000;
            rdata_r     <= 32'h0000_0000;
        end else begin
            state_r     <= state_s;
            bus_req_r   <= bus_req_s;
            bus_we_r    <= bus_we_s;
            bus_addr_r  <= bus_addr_s;
            bus_sel_r   <= bus_sel_s;
            bus_wdata_r <= bus_wdata_s;
            rdata_r     <= rdata_s;
        end
    end

    assign bus_req   = bus_req_r;
    assign bus_we    = bus_we_r;
    assign bus_addr  = bus_addr_r;
    assign bus_sel   = bus_sel_r;
    assign bus_wdata = bus_wdata_r;

    // Writeback and stall outputs; loads never forward before their data.
    always_comb begin
        en_wd_o       = en_wd_i;
        desReg_addr_o = desReg_addr_i;
        result_o      = result_i;
        stall_req     = 1'b0;
        case (state_r)
            IDLE: begin
                if (is_load_s | is_store_s) begin
                    en_wd_o   = 1'b0;
                    stall_req = mem_op_s;
                end else begin
                    en_wd_o = en_wd_i;
                end
            end
            BUSY: begin
                en_wd_o   = 1'b0;
                stall_req = 1'b1;
            end
            DONE: begin
                if (is_load_s) begin
                    en_wd_o  = en_wd_i;
                    result_o = load_extract(size_s, sext_s, ram_addr_i[1:0], rdata_r);
                end else begin
                    en_wd_o = 1'b0;
                end
            end
            default: begin
                en_wd_o   = 1'b0;
                stall_req = 1'b0;
            end
        endcase
    end

endmodule
